// File: rtl/motor_mixer.sv
// Quad-X motor mixer: latches throttle and PID rates on a start edge, computes one
// saturated motor command per clock, then commits all four at once and pulses complete.
// Optional throttle cutoff: define MOTOR_MIXER_THROTTLE_CUTOFF_EN.
module motor_mixer #(
  parameter int                 RATE_W    = 16,
  parameter int                 MOTOR_W   = 16,
  parameter logic [MOTOR_W-1:0] MOTOR_MIN = 16'h0000,
  parameter logic [MOTOR_W-1:0] MOTOR_MAX = 16'hFFFF
`ifdef MOTOR_MIXER_THROTTLE_CUTOFF_EN
  , parameter logic [MOTOR_W-1:0] CUTOFF_THRESHOLD = 16'd100
`endif
) (
  input  logic               us_clk,
  input  logic               resetn,
  input  logic               start_signal,
  input  logic [MOTOR_W-1:0] throttle_in,
  input  logic [RATE_W-1:0]  yaw_rate_in,
  input  logic [RATE_W-1:0]  roll_rate_in,
  input  logic [RATE_W-1:0]  pitch_rate_in,
  output logic [MOTOR_W-1:0] motor_1_out,
  output logic [MOTOR_W-1:0] motor_2_out,
  output logic [MOTOR_W-1:0] motor_3_out,
  output logic [MOTOR_W-1:0] motor_4_out,
  output logic               busy,
  output logic               complete_signal
);

  // Three extra bits hold T plus three full-scale rates without wrapping.
  localparam int SUM_W = MOTOR_W + 3;
  typedef logic signed [SUM_W-1:0] sum_t;
  localparam sum_t MIN_S = {3'b000, MOTOR_MIN};
  localparam sum_t MAX_S = {3'b000, MOTOR_MAX};

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    CALC   = 3'b010,
    COMMIT = 3'b100
  } state_t;

  state_t             state;
  logic               start_prev;
  logic               start_edge;
  logic [1:0]         idx;
  logic [MOTOR_W-1:0] t_lat;
  logic [RATE_W-1:0]  y_lat, r_lat, p_lat;
  logic [MOTOR_W-1:0] shadow [4];
  logic [MOTOR_W-1:0] mixed;

  assign start_edge = start_signal & ~start_prev;

  // Mix and saturate the motor selected by idx from the latched operands.
  always_comb begin
    sum_t t_ext, y_ext, r_ext, p_ext, sum;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mixed = '0;
    t_ext = {3'b000, t_lat};
    y_ext = {{(SUM_W-RATE_W){y_lat[RATE_W-1]}}, y_lat};
    r_ext = {{(SUM_W-RATE_W){r_lat[RATE_W-1]}}, r_lat};
    p_ext = {{(SUM_W-RATE_W){p_lat[RATE_W-1]}}, p_lat};
    case (idx)
      2'd0:    sum = t_ext + p_ext - r_ext - y_ext;
      2'd1:    sum = t_ext + p_ext + r_ext + y_ext;
      2'd2:    sum = t_ext - p_ext + r_ext - y_ext;
      default: sum = t_ext - p_ext - r_ext + y_ext;
    endcase
    if (sum < MIN_S)      mixed = MOTOR_MIN;
    else if (sum > MAX_S) mixed = MOTOR_MAX;
    else                  mixed = sum[MOTOR_W-1:0];
`ifdef MOTOR_MIXER_THROTTLE_CUTOFF_EN
    if (t_lat < CUTOFF_THRESHOLD) mixed = '0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      start_prev      <= 1'b0;
      idx             <= 2'd0;
      t_lat           <= '0;
      y_lat           <= '0;
      r_lat           <= '0;
      p_lat           <= '0;
      motor_1_out     <= '0;
      motor_2_out     <= '0;
      motor_3_out     <= '0;
      motor_4_out     <= '0;
      busy            <= 1'b0;
      complete_signal <= 1'b0;
      // NOTE: the shadow array is only four words, so it is reset like ordinary flops.
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else begin
      start_prev      <= start_signal;
      complete_signal <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            t_lat <= throttle_in;
            y_lat <= yaw_rate_in;
            r_lat <= roll_rate_in;
            p_lat <= pitch_rate_in;
            idx   <= 2'd0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          shadow[idx] <= mixed;
          idx         <= idx + 2'd1;
          if (idx == 2'd3) state <= COMMIT;
        end
        COMMIT: begin
          motor_1_out     <= shadow[0];
          motor_2_out     <= shadow[1];
          motor_3_out     <= shadow[2];
          motor_4_out     <= shadow[3];
          complete_signal <= 1'b1;
          busy            <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
